// File: rtl/branch_redirect_ctrl_if.sv
// Bundle of mem-stage, fetch-redirect and BTB-write signals for branch_redirect_ctrl.
// slave is the controller side; master is the pipeline/driver side.
interface branch_redirect_ctrl_if;
    logic        mem_valid;
    logic        mem_hold;
    logic [31:0] mem_pc;
    logic        modify_pc;
    logic [31:0] update_pc;
    logic        btb_update;
    logic [31:0] btb_update_target;
    logic        branch_taken;
    logic        fetch_ready;
    logic        btb_wr_ready;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        flush_ex;
    logic        btb_wr_valid;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        btb_wr_taken;
    logic        stall_req;

    modport master (
        output mem_valid, mem_hold, mem_pc, modify_pc, update_pc,
               btb_update, btb_update_target, branch_taken,
               fetch_ready, btb_wr_ready,
        input  redirect_valid, redirect_pc, flush_if, flush_id, flush_ex,
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, stall_req
    );

    modport slave (
        input  mem_valid, mem_hold, mem_pc, modify_pc, update_pc,
               btb_update, btb_update_target, branch_taken,
               fetch_ready, btb_wr_ready,
        output redirect_valid, redirect_pc, flush_if, flush_id, flush_ex,
               btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken, stall_req
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Mem-stage redirect controller with a BTB training queue.
// Define REDIRECT_PERF_CNT_EN to add redirect_count / btb_stall_count outputs.
module branch_redirect_ctrl #(
    parameter int unsigned BTB_Q_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_redirect_ctrl_if.slave   bus
`ifdef REDIRECT_PERF_CNT_EN
    ,
    output logic [31:0]             redirect_count,
    output logic [31:0]             btb_stall_count
`endif
);

    localparam int unsigned PTR_W = $clog2(BTB_Q_DEPTH);
    localparam int unsigned CNT_W = $clog2(BTB_Q_DEPTH) + 1;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       target_q;

    logic [31:0]       q_pc     [BTB_Q_DEPTH];
    logic [31:0]       q_target [BTB_Q_DEPTH];
    logic [BTB_Q_DEPTH-1:0] q_taken;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic empty;
    logic stall;
    logic accept;
    logic capture;
    logic push;
    logic pop;

    // A full queue only blocks the mem stage when the BTB cannot drain this cycle,
    // so accept never pushes into a queue that is not also popping.
    always_comb begin
        full    = (count == CNT_W'(BTB_Q_DEPTH));
        empty   = (count == '0);
        stall   = !rst && bus.mem_valid && bus.btb_update && full && !bus.btb_wr_ready;
        accept  = !rst && bus.mem_valid && !bus.mem_hold && !stall && (state == IDLE);
        capture = accept && bus.modify_pc;
        push    = accept && bus.btb_update;
        pop     = !rst && !empty && bus.btb_wr_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            target_q <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                target_q <= bus.update_pc;
            end
        end
    end

    always_comb begin
        state_next         = state;
        bus.redirect_valid = 1'b0;
        bus.flush_if       = 1'b0;
        bus.flush_id       = 1'b0;
        bus.flush_ex       = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next   = REDIRECT;
                    bus.flush_if = 1'b1;
                    bus.flush_id = 1'b1;
                    bus.flush_ex = 1'b1;
                end
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.flush_if       = !rst;
                bus.flush_id       = !rst;
                bus.flush_ex       = !rst;
                if (bus.fetch_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.redirect_pc   = target_q;
        bus.stall_req     = stall;
        bus.btb_wr_valid  = !rst && !empty;
        bus.btb_wr_pc     = q_pc[rd_ptr];
        bus.btb_wr_target = q_target[rd_ptr];
        bus.btb_wr_taken  = q_taken[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]     <= bus.mem_pc;
            q_target[wr_ptr] <= bus.btb_update_target;
            q_taken[wr_ptr]  <= bus.branch_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef REDIRECT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_count  <= '0;
            btb_stall_count <= '0;
        end else begin
            if (capture) begin
                redirect_count <= redirect_count + 32'd1;
            end
            if (stall) begin
                btb_stall_count <= btb_stall_count + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_branch_redirect_ctrl;

    localparam int unsigned DEPTH = 2;

    logic clk;
    logic rst;
    branch_redirect_ctrl_if bus();
`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] redirect_count;
    logic [31:0] btb_stall_count;
`endif

    branch_redirect_ctrl #(.BTB_Q_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus)
`ifdef REDIRECT_PERF_CNT_EN
        ,
        .redirect_count  (redirect_count),
        .btb_stall_count (btb_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, mv, mh, mod, bu, bt, fr, wr;
        logic [31:0] mpc, upc, tgt;
        logic        ef, es, erv;
        logic [31:0] erpc;
        logic        ewv;
        logic [31:0] ewpc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t        mq[$];
    bit          m_redir;
    logic [31:0] m_tgt;
    bit          m_acc;
    bit          m_wv;
    bit          m_stall;
    logic [31:0] m_redirects;
    logic [31:0] m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, mv, mh, mod, bu, bt, fr, wr,
                                input logic [31:0] mpc, upc, tgt,
                                input logic ef, es, erv, input logic [31:0] erpc,
                                input logic ewv, input logic [31:0] ewpc);
        vec_t v;
        v.rst = r; v.mv = mv; v.mh = mh; v.mod = mod; v.bu = bu; v.bt = bt;
        v.fr = fr; v.wr = wr; v.mpc = mpc; v.upc = upc; v.tgt = tgt;
        v.ef = ef; v.es = es; v.erv = erv; v.erpc = erpc; v.ewv = ewv; v.ewpc = ewpc;
        return v;
    endfunction

    function automatic vec_t iv();
        return mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    endfunction

    task automatic drive(input vec_t v);
        rst                   = v.rst;
        bus.mem_valid         = v.mv;
        bus.mem_hold          = v.mh;
        bus.modify_pc         = v.mod;
        bus.btb_update        = v.bu;
        bus.branch_taken      = v.bt;
        bus.fetch_ready       = v.fr;
        bus.btb_wr_ready      = v.wr;
        bus.mem_pc            = v.mpc;
        bus.update_pc         = v.upc;
        bus.btb_update_target = v.tgt;
    endtask

    task automatic model_check();
        logic ef;
        m_stall = !rst && bus.mem_valid && bus.btb_update && (mq.size() == DEPTH) && !bus.btb_wr_ready;
        m_acc   = !rst && bus.mem_valid && !bus.mem_hold && !m_stall && !m_redir;
        m_wv    = !rst && (mq.size() != 0);
        ef      = !rst && (m_redir || (m_acc && bus.modify_pc));
        chk("model_stall_req", bus.stall_req, m_stall);
        chk("model_flush_if", bus.flush_if, ef);
        chk("model_flush_id", bus.flush_id, ef);
        chk("model_flush_ex", bus.flush_ex, ef);
        chk("model_redirect_valid", bus.redirect_valid, m_redir);
        if (m_redir) chk("model_redirect_pc", bus.redirect_pc, m_tgt);
        chk("model_btb_wr_valid", bus.btb_wr_valid, m_wv);
        if (m_wv) begin
            chk("model_btb_wr_pc", bus.btb_wr_pc, mq[0].pc);
            chk("model_btb_wr_target", bus.btb_wr_target, mq[0].tgt);
            chk("model_btb_wr_taken", bus.btb_wr_taken, mq[0].tk);
        end
    endtask

    task automatic model_update();
        ent_t e;
        if (rst) begin
            mq.delete();
            m_redir     = 0;
            m_tgt       = '0;
            m_redirects = '0;
            m_stalls    = '0;
        end else begin
            if (m_stall) m_stalls = m_stalls + 1;
            if (m_wv && bus.btb_wr_ready) void'(mq.pop_front());
            if (m_acc && bus.btb_update) begin
                e.pc = bus.mem_pc; e.tgt = bus.btb_update_target; e.tk = bus.branch_taken;
                mq.push_back(e);
            end
            if (m_redir) begin
                if (bus.fetch_ready) m_redir = 0;
            end else if (m_acc && bus.modify_pc) begin
                m_redir     = 1;
                m_tgt       = bus.update_pc;
                m_redirects = m_redirects + 1;
            end
        end
    endtask

    task automatic step(input vec_t v, input bit hand, input int idx);
        drive(v);
        @(negedge clk);
        model_check();
        if (hand) begin
            chk($sformatf("vec%0d_flush_if", idx), bus.flush_if, v.ef);
            chk($sformatf("vec%0d_flush_id", idx), bus.flush_id, v.ef);
            chk($sformatf("vec%0d_flush_ex", idx), bus.flush_ex, v.ef);
            chk($sformatf("vec%0d_stall_req", idx), bus.stall_req, v.es);
            chk($sformatf("vec%0d_redirect_valid", idx), bus.redirect_valid, v.erv);
            if (v.erv) chk($sformatf("vec%0d_redirect_pc", idx), bus.redirect_pc, v.erpc);
            chk($sformatf("vec%0d_btb_wr_valid", idx), bus.btb_wr_valid, v.ewv);
            if (v.ewv) chk($sformatf("vec%0d_btb_wr_pc", idx), bus.btb_wr_pc, v.ewpc);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drain();
        vec_t v;
        v = iv(); v.wr = 1; v.fr = 1;
        for (int k = 0; k < 4; k++) step(v, 0, 0);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t v;

        tbl[0]  = mk(1,0,0,0,0,0,0,0, 32'h0,  32'h0,   32'h0,    0,0,0,32'h0,  0,32'h0);
        tbl[1]  = mk(0,1,0,1,0,0,1,1, 32'h40, 32'h100, 32'h0,    1,0,0,32'h0,  0,32'h0);
        tbl[2]  = mk(0,0,0,0,0,0,1,1, 32'h0,  32'h0,   32'h0,    1,0,1,32'h100,0,32'h0);
        tbl[3]  = mk(0,0,0,0,0,0,1,1, 32'h0,  32'h0,   32'h0,    0,0,0,32'h0,  0,32'h0);
        tbl[4]  = mk(0,1,0,0,1,1,0,0, 32'h10, 32'h0,   32'h1010, 0,0,0,32'h0,  0,32'h0);
        tbl[5]  = mk(0,1,0,0,1,0,0,0, 32'h14, 32'h0,   32'h1014, 0,0,0,32'h0,  1,32'h10);
        tbl[6]  = mk(0,1,0,0,1,1,0,0, 32'h18, 32'h0,   32'h1018, 0,1,0,32'h0,  1,32'h10);
        tbl[7]  = mk(0,1,0,0,1,1,0,1, 32'h18, 32'h0,   32'h1018, 0,0,0,32'h0,  1,32'h10);
        tbl[8]  = mk(0,0,0,0,0,0,0,1, 32'h0,  32'h0,   32'h0,    0,0,0,32'h0,  1,32'h14);
        tbl[9]  = mk(0,0,0,0,0,0,0,1, 32'h0,  32'h0,   32'h0,    0,0,0,32'h0,  1,32'h18);
        tbl[10] = mk(0,0,0,0,0,0,0,1, 32'h0,  32'h0,   32'h0,    0,0,0,32'h0,  0,32'h0);
        tbl[11] = mk(0,1,1,1,1,0,0,1, 32'h20, 32'h200, 32'h2020, 0,0,0,32'h0,  0,32'h0);
        tbl[12] = mk(0,0,0,0,0,0,0,1, 32'h0,  32'h0,   32'h0,    0,0,0,32'h0,  0,32'h0);

        // Unchecked power-on reset so register state is defined before comparisons.
        v = iv(); v.rst = 1;
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); m_redir = 0; m_tgt = '0; m_redirects = '0; m_stalls = '0;
        chk("reset_redirect_pc", bus.redirect_pc, 32'h0);
        chk("reset_redirect_valid", bus.redirect_valid, 1'b0);

        for (int i = 0; i < 13; i++) step(tbl[i], 1, i);

        // Redirect held for 4 cycles; wrong-path mem_valid pulses must not push.
        drain();
        v = iv(); v.mv = 1; v.mod = 1; v.upc = 32'h300;
        step(v, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d_redirect_valid", k), bus.redirect_valid, 1'b1);
            chk($sformatf("hold%0d_redirect_pc", k), bus.redirect_pc, 32'h300);
            v = iv(); v.mv = (k % 2 == 0); v.bu = 1; v.mod = 1; v.upc = 32'h999;
            v.mpc = 32'h50 + k; v.fr = (k == 3);
            step(v, 0, 0);
        end
        chk("hold_end_redirect_valid", bus.redirect_valid, 1'b0);
        chk("hold_no_push_btb_wr_valid", bus.btb_wr_valid, 1'b0);

        // Reset during REDIRECT with two queued entries.
        drain();
        v = iv(); v.mv = 1; v.bu = 1; v.mpc = 32'h60; v.tgt = 32'h600;
        step(v, 0, 0);
        v.mpc = 32'h64; v.tgt = 32'h640;
        step(v, 0, 0);
        v = iv(); v.mv = 1; v.mod = 1; v.upc = 32'h380;
        step(v, 0, 0);
        chk("rstred_pre_redirect_valid", bus.redirect_valid, 1'b1);
        chk("rstred_pre_btb_wr_valid", bus.btb_wr_valid, 1'b1);
        v = iv(); v.rst = 1; v.mv = 1; v.mod = 1; v.bu = 1; v.fr = 1; v.wr = 1; v.upc = 32'h480;
        step(v, 0, 0);
        drive(iv());
        #1;
        chk("rstred_redirect_valid", bus.redirect_valid, 1'b0);
        chk("rstred_btb_wr_valid", bus.btb_wr_valid, 1'b0);
        v = iv(); v.mv = 1; v.mod = 1; v.upc = 32'h400; v.fr = 1;
        step(v, 0, 0);
        chk("rstred_idle_accepts_redirect_pc", bus.redirect_pc, 32'h400);
        chk("rstred_idle_accepts_valid", bus.redirect_valid, 1'b1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            v = iv();
            v.rst = ($urandom_range(63) == 0);
            v.mv  = $urandom_range(1);
            v.mh  = ($urandom_range(4) == 0);
            v.mod = ($urandom_range(3) == 0);
            v.bu  = $urandom_range(1);
            v.bt  = $urandom_range(1);
            v.fr  = $urandom_range(1);
            v.wr  = ($urandom_range(2) == 0);
            v.mpc = $urandom; v.upc = $urandom; v.tgt = $urandom;
            step(v, 0, 0);
        end

`ifdef REDIRECT_PERF_CNT_EN
        chk("perf_redirect_count", redirect_count, m_redirects);
        chk("perf_btb_stall_count", btb_stall_count, m_stalls);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter BTB_Q_DEPTH, default 2, BTB update queue depth (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_valid  input  1  valid resolved control-flow result in mem stage.
REQ-005 SHALL have port mem_hold  input  1  external mem-stage stall (e.g. mul/div busy).
REQ-006 SHALL have port mem_pc  input  32  PC of mem-stage instruction.
REQ-007 SHALL have port modify_pc  input  1  resolver demands fetch redirect.
REQ-008 SHALL have port update_pc  input  32  redirect target.
REQ-009 SHALL have port btb_update, btb_update_target, branch_taken  input  1/32/1  BTB training request, target, taken.
REQ-010 SHALL have port fetch_ready  input  1  fetch accepts redirect this cycle.
REQ-011 SHALL have port btb_wr_ready  input  1  BTB write port free.
REQ-012 SHALL have port redirect_valid, redirect_pc  output  1/32  registered redirect request to fetch.
REQ-013 SHALL have port flush_if, flush_id, flush_ex  output  1 each  squash younger stages.
REQ-014 SHALL have port btb_wr_valid, btb_wr_pc, btb_wr_target, btb_wr_taken  output  1/32/32/1  BTB write request.
REQ-015 SHALL have port stall_req  output  1  hold mem stage; BTB queue cannot accept.

Function
REQ-016 SHALL define accept = mem_valid & !mem_hold & !stall_req & (state==IDLE).
REQ-017 SHALL implement FSM states IDLE and REDIRECT; reset state IDLE.
REQ-018 SHALL, on accept & modify_pc in IDLE, capture update_pc and enter REDIRECT next cycle.
REQ-019 SHALL assert flush_if, flush_id, flush_ex combinationally in the cycle accept & modify_pc holds.
REQ-020 SHALL in REDIRECT drive redirect_valid=1, redirect_pc=captured target, flush_if=1, flush_id=1, flush_ex=1.
REQ-021 SHALL hold redirect_valid and redirect_pc stable until fetch_ready; REDIRECT->IDLE in the cycle after redirect_valid & fetch_ready.
REQ-022 SHALL ignore mem_valid while in REDIRECT (wrong-path bubbles); no push, no capture.
REQ-023 SHALL push {mem_pc, btb_update_target, branch_taken} into the FIFO on accept & btb_update, independent of modify_pc.
REQ-024 SHALL drive btb_wr_valid = FIFO not empty, btb_wr_* = FIFO head; pop on btb_wr_valid & btb_wr_ready.
REQ-025 SHALL drive stall_req = mem_valid & btb_update & full & !btb_wr_ready (combinational).
REQ-026 SHALL allow push and pop in one cycle when full and btb_wr_ready=1; occupancy unchanged, no stall.
REQ-027 SHALL keep FIFO order; pointers wrap modulo BTB_Q_DEPTH; occupancy counter width clog2(BTB_Q_DEPTH)+1.
REQ-028 SHALL never drop or duplicate a BTB update; a stalled event is retried by upstream holding inputs.

Reset
REQ-029 SHALL on rst force state IDLE, FIFO empty, redirect_valid=0, redirect_pc=0, btb_wr_valid=0, all flush=0, stall_req=0.
REQ-030 SHALL give rst priority over every simultaneous accept, push, pop or fetch_ready; pending redirect discarded.

Configuration
REQ-031 SHALL, when REDIRECT_PERF_CNT_EN defined, add outputs redirect_count[31:0] (+1 per entry to REDIRECT) and btb_stall_count[31:0] (+1 per cycle stall_req=1), both wrap, reset to 0.
REQ-032 SHALL, without REDIRECT_PERF_CNT_EN, omit both ports and counters; other behaviour identical.

Verification
REQ-033 SHALL cover: accept modify_pc=1, update_pc=0x0000_0100, fetch_ready=1 -> flushes same cycle, redirect_valid=1 pc=0x100 for exactly 1 cycle, then IDLE.
REQ-034 SHALL cover: redirect with fetch_ready=0 for 3 cycles -> redirect_valid/pc held 4 cycles, mem_valid pulses during hold produce no push.
REQ-035 SHALL cover: BTB_Q_DEPTH=2, btb_wr_ready=0, 3 updates (pc 0x10,0x14,0x18) -> 3rd raises stall_req; btb_wr_ready=1 -> pops 0x10,0x14,0x18 in order.
REQ-036 SHALL cover: full FIFO, btb_wr_ready=1, new update -> no stall_req, push+pop same cycle, occupancy stays 2.
REQ-037 SHALL cover: rst asserted during REDIRECT with 2 queued entries -> next cycle redirect_valid=0, btb_wr_valid=0, state IDLE.
REQ-038 SHALL cover (REDIRECT_PERF_CNT_EN): 2 redirects, 3 stall cycles -> redirect_count=2, btb_stall_count=3.
